mem_stage: RTL and testbench
============================

# mem_stage

Parametrised memory stage for the ARM pipeline, sitting between the EXE stage and the WB stage. It completes loads and stores against an internal word-addressed data memory with a configurable number of wait states. While an access is in flight it raises `stall` to freeze upstream stages and sends bubbles toward WB. All other instructions pass through with one cycle of latency and drive the registered WB-side outputs.

## Interface
Parameters:
- `DATA_W`, 32, data and address width.
- `DEPTH`, 64, number of data-memory words; a power of two.
- `BASE_ADDR`, 1024, byte address of word 0.
- `WAIT_STATES`, 0, extra cycles per load or store; range 0–15.

Ports:
- `clk` input 1: the block's single clock.
- `rst` input 1: asynchronous, active-high reset.
- `WB_EN_IN`, `MEM_R_EN_IN`, `MEM_W_EN_IN` input 1 each: control signals from EXE.
- `ALU_result_IN` input DATA_W: effective byte address, or the ALU value for non-memory instructions.
- `Val_Rm` input DATA_W: store data.
- `Dest_IN` input 4: destination register.
- `WB_EN`, `MEM_R_EN` output 1 each: registered controls sent to WB.
- `ALU_result`, `Mem_result` output DATA_W: registered ALU value and load data.
- `Dest` output 4: registered destination register.
- `stall` output 1: combinational; freezes the IF/ID/EXE stages.
- `mem_err` output 1: sticky error flag for range or alignment faults.

## Operation
- States:
  - IDLE: no access in flight.
  - BUSY: access in flight; a wait counter `cnt` of 4 bits runs from 1 to WAIT_STATES.
- Memory op means `MEM_R_EN_IN | MEM_W_EN_IN`. If both are set, treat the op as a read; the write is ignored.
- IDLE, no memory op: capture the inputs into the output register at the next edge. `Mem_result` = 0.
- IDLE, memory op, WAIT_STATES=0: complete the op at the next edge. `stall` stays 0.
- IDLE, memory op, WAIT_STATES>0:
  - `stall` = 1.
  - Go to BUSY with `cnt` = 1.
  - Output register loads a bubble: `WB_EN` = 0, `MEM_R_EN` = 0, `Dest` = 0.
- BUSY:
  - `stall` = (`cnt` != WAIT_STATES).
  - While stalling, increment `cnt` and keep loading bubbles.
  - When `cnt` == WAIT_STATES, complete the op at that edge and return to IDLE.
- Completion edge:
  - Word index = (`ALU_result_IN` − BASE_ADDR) >> 2.
  - Write: `mem[idx] <= Val_Rm`.
  - Read: `Mem_result <= mem[idx]`.
  - `WB_EN`, `MEM_R_EN`, `ALU_result` and `Dest` take their input values.
- Fault: address < BASE_ADDR, address ≥ BASE_ADDR + 4·DEPTH, or `addr[1:0]` != 0.
  - No write occurs; `Mem_result` = 0.
  - `mem_err` is set to 1 and stays set until reset.
  - Timing is unchanged.
- Upstream holds the inputs stable while `stall` = 1. The block samples the inputs only at the completion edge.
- Memory contents are not reset.

## Timing
- Reset values: every output is 0, the state is IDLE and `cnt` = 0.
- Latency from input to WB outputs:
  - Non-memory op: 1 cycle.
  - Memory op: WAIT_STATES + 1 cycles.
- A memory op keeps `stall` high for exactly WAIT_STATES cycles.
- Back-to-back memory ops with WAIT_STATES = W: a new op is accepted in IDLE on the cycle after completion. Throughput is one op per W+1 cycles.
- Reset asserted mid-BUSY:
  - The access aborts with no write.
  - `stall` drops immediately through the asynchronous path.
  - The state returns to IDLE.
- A write followed by a read of the same address returns the new data (the write completes first).

## Structure
- Shared package `arm_pkg` holds:
  - `REG_ADDR_W` = 4.
  - The `mem_state_t` enum {IDLE, BUSY}.
  - Default constants for `BASE_ADDR` and `WAIT_STATES`.
- One natural sub-module, `data_sram`: a synchronous-write, read-registered word array of parameterised DEPTH and DATA_W. The FSM, counter and WB-side pipeline register stay in `mem_stage`.

## Test plan
1. Non-memory op, WAIT_STATES=0: ALU 0x5, Dest 3, WB_EN 1 → next cycle `WB_EN` = 1, `ALU_result` = 0x5, `Dest` = 3, `stall` stays 0.
2. WAIT_STATES=0: store 0xDEADBEEF to 1028, then load from 1028 with Dest 7 → one cycle after the load, `Mem_result` = 0xDEADBEEF, `MEM_R_EN` = 1, `Dest` = 7.
3. WAIT_STATES=3, load from 1024:
   - `stall` is high for 3 cycles.
   - Bubbles are sent for those 3 cycles.
   - Data appears at cycle 4.
4. Load from 1000, 1026 and 1024+4·64:
   - `Mem_result` = 0 each time.
   - `mem_err` = 1 after the first fault and stays set.
   - A following store to 1024 does not clear `mem_err`.
5. WAIT_STATES=3: store to 1032 with `rst` pulsed at wait cycle 2, then a load from 1032 → the load returns the value held before the store. `stall` = 0 and all outputs are 0 during reset.
6. WAIT_STATES=2: two back-to-back loads → `stall` high for 2 cycles each, completions 3 cycles apart.

Source files
------------

// File: rtl/arm_pkg.sv
// Shared types and defaults for the ARM pipeline memory stage.
// Register address width, memory FSM states and stage parameter defaults.
package arm_pkg;
  localparam int REG_ADDR_W = 4;
  localparam int DEF_BASE_ADDR = 1024;
  localparam int DEF_WAIT_STATES = 0;

  typedef enum logic {
    IDLE,
    BUSY
  } mem_state_t;
endpackage

// File: rtl/mem_stage_data_sram.sv
// Word-addressed data array: synchronous write, registered read.
// Contents and read register are intentionally not reset.
module data_sram #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: loads/stores with wait states, stall generation,
// bubble insertion and the registered WB-side outputs.
module mem_stage
  import arm_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH = 64,
  parameter int BASE_ADDR = DEF_BASE_ADDR,
  parameter int WAIT_STATES = DEF_WAIT_STATES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WB_EN_IN,
  input  logic                  MEM_R_EN_IN,
  input  logic                  MEM_W_EN_IN,
  input  logic [DATA_W-1:0]     ALU_result_IN,
  input  logic [DATA_W-1:0]     Val_Rm,
  input  logic [REG_ADDR_W-1:0] Dest_IN,
  output logic                  WB_EN,
  output logic                  MEM_R_EN,
  output logic [DATA_W-1:0]     ALU_result,
  output logic [DATA_W-1:0]     Mem_result,
  output logic [REG_ADDR_W-1:0] Dest,
  output logic                  stall,
  output logic                  mem_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [DATA_W-1:0] LO = DATA_W'(BASE_ADDR);
  localparam logic [DATA_W-1:0] HI = DATA_W'(BASE_ADDR + 4 * DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);
  localparam bit NO_WAIT = (WAIT_STATES == 0);

  mem_state_t state;
  logic [3:0] cnt;
  logic rd_vld;

  logic rd, wr, mem_op, bad;
  logic busy_done, start_wait, cap, done;
  logic [DATA_W-1:0] off;
  logic [AW-1:0] idx;
  logic [DATA_W-1:0] sram_q;

  // Read wins when both enables are set
  assign rd = MEM_R_EN_IN;
  assign wr = MEM_W_EN_IN & ~MEM_R_EN_IN;
  assign mem_op = rd | wr;

  assign off = ALU_result_IN - LO;
  assign idx = AW'(off >> 2);
  assign bad = (ALU_result_IN < LO) || (ALU_result_IN >= HI)
            || (ALU_result_IN[1:0] != 2'b00);

  assign busy_done = (state == BUSY) && (cnt == WS);
  assign start_wait = (state == IDLE) && mem_op && !NO_WAIT;
  assign cap = ((state == IDLE) && !start_wait) || busy_done;
  assign done = cap && mem_op;

  // Reset gating keeps stall low while rst is held with a pending op
  assign stall = !rst && (start_wait
              || ((state == BUSY) && (cnt != WS)));

  data_sram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH)
  ) u_sram (
    .clk  (clk),
    .we   (done & wr & ~bad),
    .re   (done & rd & ~bad),
    .addr (idx),
    .wdata(Val_Rm),
    .rdata(sram_q)
  );

  assign Mem_result = rd_vld ? sram_q : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      WB_EN <= 1'b0;
      MEM_R_EN <= 1'b0;
      ALU_result <= '0;
      Dest <= '0;
      rd_vld <= 1'b0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_wait) begin
            state <= BUSY;
            cnt <= 4'd1;
          end
        end
        BUSY: begin
          if (cnt == WS) begin
            state <= IDLE;
            cnt <= '0;
          end else begin
            cnt <= cnt + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt <= '0;
        end
      endcase
      if (cap) begin
        WB_EN <= WB_EN_IN;
        MEM_R_EN <= MEM_R_EN_IN;
        ALU_result <= ALU_result_IN;
        Dest <= Dest_IN;
        rd_vld <= rd & ~bad;
        if (mem_op && bad) mem_err <= 1'b1;
      end else begin
        WB_EN <= 1'b0;
        MEM_R_EN <= 1'b0;
        ALU_result <= '0;
        Dest <= '0;
        rd_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage with 0, 3 and 2 wait states.
// Stimulus pushes expected WB results; a negedge monitor pops them.
module tb_mem_stage;
  import arm_pkg::*;

  typedef struct packed {
    logic        wb;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [3:0]  dest;
  } exp_t;

  localparam int WS0 = 0;
  localparam int WS1 = 3;
  localparam int WS2 = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic wb_i [3];
  logic r_i [3];
  logic w_i [3];
  logic [31:0] alu_i [3];
  logic [31:0] val_i [3];
  logic [3:0] dest_i [3];

  logic o_wb [3];
  logic o_mr [3];
  logic [31:0] o_alu [3];
  logic [31:0] o_mem [3];
  logic [3:0] o_dest [3];
  logic o_stall [3];
  logic o_err [3];

  exp_t q [3][$];
  int checks = 0;
  int errors = 0;
  int ws [3];

  always #5 clk = ~clk;

  mem_stage #(.WAIT_STATES(WS0)) u0 (
    .clk(clk), .rst(rst),
    .WB_EN_IN(wb_i[0]), .MEM_R_EN_IN(r_i[0]), .MEM_W_EN_IN(w_i[0]),
    .ALU_result_IN(alu_i[0]), .Val_Rm(val_i[0]), .Dest_IN(dest_i[0]),
    .WB_EN(o_wb[0]), .MEM_R_EN(o_mr[0]), .ALU_result(o_alu[0]),
    .Mem_result(o_mem[0]), .Dest(o_dest[0]),
    .stall(o_stall[0]), .mem_err(o_err[0])
  );

  mem_stage #(.WAIT_STATES(WS1)) u1 (
    .clk(clk), .rst(rst),
    .WB_EN_IN(wb_i[1]), .MEM_R_EN_IN(r_i[1]), .MEM_W_EN_IN(w_i[1]),
    .ALU_result_IN(alu_i[1]), .Val_Rm(val_i[1]), .Dest_IN(dest_i[1]),
    .WB_EN(o_wb[1]), .MEM_R_EN(o_mr[1]), .ALU_result(o_alu[1]),
    .Mem_result(o_mem[1]), .Dest(o_dest[1]),
    .stall(o_stall[1]), .mem_err(o_err[1])
  );

  mem_stage #(.WAIT_STATES(WS2)) u2 (
    .clk(clk), .rst(rst),
    .WB_EN_IN(wb_i[2]), .MEM_R_EN_IN(r_i[2]), .MEM_W_EN_IN(w_i[2]),
    .ALU_result_IN(alu_i[2]), .Val_Rm(val_i[2]), .Dest_IN(dest_i[2]),
    .WB_EN(o_wb[2]), .MEM_R_EN(o_mr[2]), .ALU_result(o_alu[2]),
    .Mem_result(o_mem[2]), .Dest(o_dest[2]),
    .stall(o_stall[2]), .mem_err(o_err[2])
  );

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic nop(int k);
    wb_i[k] = 1'b0;
    r_i[k] = 1'b0;
    w_i[k] = 1'b0;
    alu_i[k] = '0;
    val_i[k] = '0;
    dest_i[k] = '0;
  endtask

  // Drive one instruction, check stall/bubbles, return after completion
  task automatic op(int k, bit wb, bit r, bit w, logic [31:0] a,
                    logic [31:0] v, logic [3:0] d, logic [31:0] em);
    exp_t e;
    int n;
    int exp_n;
    wb_i[k] = wb;
    r_i[k] = r;
    w_i[k] = w;
    alu_i[k] = a;
    val_i[k] = v;
    dest_i[k] = d;
    if (wb || r) begin
      e = '{wb: wb, mr: r, alu: a, mem: em, dest: d};
      q[k].push_back(e);
    end
    exp_n = (r || w) ? ws[k] : 0;
    n = 0;
    #1;
    while (o_stall[k] && n < 20) begin
      n++;
      @(posedge clk);
      #1;
      chk($sformatf("bubble_wb%0d", k), 32'(o_wb[k]), 0);
      chk($sformatf("bubble_dest%0d", k), 32'(o_dest[k]), 0);
      chk($sformatf("bubble_mem%0d", k), o_mem[k], 0);
      #1;
    end
    chk($sformatf("stall_cycles%0d", k), n, exp_n);
    @(posedge clk);
    #1;
    nop(k);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      for (int k = 0; k < 3; k++) begin
        if (o_wb[k] || o_mr[k]) begin
          if (q[k].size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out%0d: wb=%0d mr=%0d dest=%0d",
                     k, o_wb[k], o_mr[k], o_dest[k]);
          end else begin
            e = q[k].pop_front();
            chk($sformatf("wb%0d", k), 32'(o_wb[k]), 32'(e.wb));
            chk($sformatf("mr%0d", k), 32'(o_mr[k]), 32'(e.mr));
            chk($sformatf("alu%0d", k), o_alu[k], e.alu);
            chk($sformatf("mem%0d", k), o_mem[k], e.mem);
            chk($sformatf("dest%0d", k), 32'(o_dest[k]), 32'(e.dest));
          end
        end
      end
    end
  end

  initial begin
    time t0;
    time t1;
    ws[0] = WS0;
    ws[1] = WS1;
    ws[2] = WS2;
    for (int k = 0; k < 3; k++) nop(k);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("rst_out", {o_wb[k], o_mr[k], o_stall[k], o_err[k]}, 0);
      chk("rst_alu", o_alu[k], 0);
      chk("rst_mem", o_mem[k], 0);
      chk("rst_dest", 32'(o_dest[k]), 0);
    end
    rst = 1'b0;

    // No wait states
    op(0, 1, 0, 0, 32'h5, 0, 4'd3, 0);
    op(0, 0, 0, 1, 1028, 32'hDEADBEEF, 0, 0);
    op(0, 1, 1, 0, 1028, 0, 4'd7, 32'hDEADBEEF);
    op(0, 0, 0, 1, 1276, 32'h0BADF00D, 0, 0);
    op(0, 1, 1, 0, 1276, 0, 4'd9, 32'h0BADF00D);
    op(0, 1, 1, 1, 1028, 32'h11111111, 4'd2, 32'hDEADBEEF);
    op(0, 1, 1, 0, 1028, 0, 4'd4, 32'hDEADBEEF);
    chk("err_clean", 32'(o_err[0]), 0);
    op(0, 1, 1, 0, 1000, 0, 4'd1, 0);
    chk("err_low", 32'(o_err[0]), 1);
    op(0, 1, 1, 0, 1026, 0, 4'd2, 0);
    op(0, 1, 1, 0, 1280, 0, 4'd3, 0);
    op(0, 0, 0, 1, 1024, 32'h5, 0, 0);
    chk("err_sticky", 32'(o_err[0]), 1);

    // Two wait states, back-to-back loads
    op(2, 0, 0, 1, 1024, 32'h11, 0, 0);
    op(2, 0, 0, 1, 1028, 32'h22, 0, 0);
    op(2, 1, 1, 0, 1024, 0, 4'd5, 32'h11);
    t0 = $time;
    op(2, 1, 1, 0, 1028, 0, 4'd6, 32'h22);
    t1 = $time;
    chk("b2b_gap", 32'(t1 - t0), 30);

    // Three wait states
    op(1, 0, 0, 1, 1024, 32'hCAFE0001, 0, 0);
    op(1, 1, 1, 0, 1024, 0, 4'd8, 32'hCAFE0001);
    op(1, 0, 0, 1, 1032, 32'hA5A5A5A5, 0, 0);

    // Store aborted by reset in its second wait cycle
    wb_i[1] = 1'b0;
    r_i[1] = 1'b0;
    w_i[1] = 1'b1;
    alu_i[1] = 1032;
    val_i[1] = 32'h12345678;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("rst_stall", 32'(o_stall[1]), 0);
    chk("rst_wb", {o_wb[1], o_mr[1], o_err[1]}, 0);
    chk("rst_alu1", o_alu[1], 0);
    chk("rst_dest1", 32'(o_dest[1]), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nop(1);
    op(1, 1, 1, 0, 1032, 0, 4'd10, 32'hA5A5A5A5);

    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) chk("q_empty", q[k].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
